// File: rtl/microwave_seq_ctrl.sv
// Microwave cook-timer sequencer: keypad BCD entry, chain load/count gating, magnetron and beeper.
// Optional feature: define QUICK_START_EN so that start in IDLE with the door closed runs a 30 s cook.
module microwave_seq_ctrl #(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic        clk_i,
  input  logic        clrn_i,
  input  logic        tick_i,
  input  logic [3:0]  digit_i,
  input  logic        digit_vld_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        door_closed_i,
  input  logic        timer_zero_i,
  output logic [15:0] cnt_data_o,
  output logic        loadn_o,
  output logic        cnt_en_o,
  output logic        mag_on_o,
  output logic        beep_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StLoad,
    StCook,
    StPause,
    StDone
  } state_e;

  localparam logic [3:0] BeepLast = 4'(BEEP_TICKS - 1);

  state_e      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [3:0]  beep_cnt_q, beep_cnt_d;
  logic        loadn_q, cook_q, beep_q, busy_q;
  logic        digit_ok;

  assign digit_ok = digit_vld_i && (digit_i <= 4'd9);

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    beep_cnt_d = '0;
    unique case (state_q)
      StIdle: begin
        if (digit_ok) begin
          entry_d = {entry_q[11:0], digit_i};
          state_d = StEntry;
        end
`ifdef QUICK_START_EN
        else if (start_i && door_closed_i) begin
          entry_d = 16'h0030;
          state_d = StLoad;
        end
`endif
      end
      StEntry: begin
        if (stop_i) begin
          entry_d = '0;
          state_d = StIdle;
        end else if (start_i && door_closed_i && (entry_q != '0)) begin
          state_d = StLoad;
        end else if (digit_ok) begin
          entry_d = {entry_q[11:0], digit_i};
        end
      end
      StLoad: state_d = StCook;
      StCook: begin
        // Reaching 00:00 outranks stop and door so the cook always ends in DONE.
        if (timer_zero_i) begin
          state_d = StDone;
        end else if (stop_i || !door_closed_i) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (stop_i) begin
          entry_d = '0;
          state_d = StIdle;
        end else if (start_i && door_closed_i) begin
          state_d = StCook;
        end
      end
      StDone: begin
        beep_cnt_d = beep_cnt_q;
        if (stop_i || (tick_i && (beep_cnt_q == BeepLast))) begin
          entry_d    = '0;
          beep_cnt_d = '0;
          state_d    = StIdle;
        end else if (tick_i) begin
          beep_cnt_d = beep_cnt_q + 4'd1;
        end
      end
      default: begin
        entry_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state_q    <= StIdle;
      entry_q    <= '0;
      beep_cnt_q <= '0;
      loadn_q    <= 1'b1;
      cook_q     <= 1'b0;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      beep_cnt_q <= beep_cnt_d;
      loadn_q    <= (state_d != StLoad);
      cook_q     <= (state_d == StCook);
      beep_q     <= (state_d == StDone);
      busy_q     <= (state_d != StIdle);
    end
  end

  assign cnt_data_o = entry_q;
  assign loadn_o    = loadn_q;
  assign beep_o     = beep_q;
  assign busy_o     = busy_q;
  // The chain must never be enabled at 00:00, otherwise it would wrap to 99:99.
  assign cnt_en_o   = cook_q && tick_i && door_closed_i && !timer_zero_i;
  assign mag_on_o   = cook_q && door_closed_i;

endmodule

// File: tb/tb_microwave_seq_ctrl.sv
// Bench for microwave_seq_ctrl: BCD chain model, load-value scoreboard, directed scenarios.
module tb_microwave_seq_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        tick, digit_vld, start, stop, door_closed, timer_zero;
  logic [3:0]  digit;
  logic [15:0] cnt_data;
  logic        loadn, cnt_en, mag_on, beep, busy;

  logic [15:0] chain;
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_loads  = 0;
  int          n_en     = 0;

  always #5 clk = ~clk;

  microwave_seq_ctrl #(.BEEP_TICKS(3)) dut (
    .clk_i         (clk),
    .clrn_i        (clrn),
    .tick_i        (tick),
    .digit_i       (digit),
    .digit_vld_i   (digit_vld),
    .start_i       (start),
    .stop_i        (stop),
    .door_closed_i (door_closed),
    .timer_zero_i  (timer_zero),
    .cnt_data_o    (cnt_data),
    .loadn_o       (loadn),
    .cnt_en_o      (cnt_en),
    .mag_on_o      (mag_on),
    .beep_o        (beep),
    .busy_o        (busy)
  );

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] == 4'd0) begin
        r[i*4 +: 4] = 4'd9;
      end else begin
        r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
        break;
      end
    end
    return r;
  endfunction

  // Model of the digit-counter chain the controller drives.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) chain <= '0;
    else if (!loadn) chain <= cnt_data;
    else if (cnt_en) chain <= bcd_dec(chain);
  end
  assign timer_zero = (chain == 16'h0000);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Every load pulse must match the value queued when start was driven.
  always @(negedge clk) begin
    if (clrn) begin
      if (cnt_en) n_en++;
      if (!loadn) begin
        n_loads++;
        if (exp_q.size() == 0) check_eq("load_unexpected", {16'h0, cnt_data}, 32'hffff_ffff);
        else check_eq("load_val", {16'h0, cnt_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_digit(input logic [3:0] d);
    digit = d; digit_vld = 1'b1;
    step();
    digit_vld = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    #1;
  endtask

  int loads_snap;

  initial begin
    clrn = 1'b0; tick = 1'b0; digit = '0; digit_vld = 1'b0;
    start = 1'b0; stop = 1'b0; door_closed = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_loadn", loadn, 1);
    check_eq("rst_cnt_en", cnt_en, 0);
    check_eq("rst_mag_on", mag_on, 0);
    check_eq("rst_beep", beep, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", cnt_data, 0);
    clrn = 1'b1;
    step();

    // Entry 1,3,0 then start: load 0x0130, magnetron on afterwards.
    pulse_digit(4'd1); pulse_digit(4'd3); pulse_digit(4'd0);
    check_eq("entry_0130", cnt_data, 16'h0130);
    check_eq("entry_busy", busy, 1);
    exp_q.push_back(16'h0130);
    pulse_start();
    check_eq("load_cycle_loadn", loadn, 0);
    check_eq("load_cycle_mag", mag_on, 0);
    step();
    check_eq("cook_loadn", loadn, 1);
    check_eq("cook_mag_on", mag_on, 1);
    check_eq("cook_chain", chain, 16'h0130);
    pulse_stop();
    check_eq("pause_mag_off", mag_on, 0);
    check_eq("pause_busy", busy, 1);
    pulse_stop();
    check_eq("stop_clear", cnt_data, 0);
    check_eq("stop_idle", busy, 0);

    // Three-second cook through DONE and the beeper.
    pulse_digit(4'd3);
    exp_q.push_back(16'h0003);
    pulse_start();
    step();
    n_en = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      step();
    end
    check_eq("en_pulses", n_en, 3);
    check_eq("done_beep", beep, 1);
    check_eq("done_mag_off", mag_on, 0);
    check_eq("done_busy", busy, 1);
    pulse_tick();
    pulse_tick();
    check_eq("beep_hold", beep, 1);
    check_eq("done_no_en", n_en, 3);
    pulse_tick();
    check_eq("beep_end", beep, 0);
    check_eq("beep_idle", busy, 0);
    check_eq("beep_clear", cnt_data, 0);

    // timer_zero visible in COOK: magnetron still on until DONE next cycle.
    pulse_digit(4'd1);
    exp_q.push_back(16'h0001);
    pulse_start();
    step();
    pulse_tick();
    check_eq("tz_mag_on", mag_on, 1);
    check_eq("tz_no_en", cnt_en, 0);
    pulse_stop();
    check_eq("tz_stop_done", beep, 1);
    pulse_stop();
    check_eq("done_stop_idle", busy, 0);
    check_eq("done_stop_beep", beep, 0);

    // Door opened on a tick cycle, then resume without reload.
    pulse_digit(4'd5);
    exp_q.push_back(16'h0005);
    pulse_start();
    step();
    door_closed = 1'b0; tick = 1'b1;
    #1;
    check_eq("door_cnt_en", cnt_en, 0);
    check_eq("door_mag_on", mag_on, 0);
    step();
    tick = 1'b0; door_closed = 1'b1;
    #1;
    check_eq("door_pause_mag", mag_on, 0);
    loads_snap = n_loads;
    pulse_start();
    check_eq("resume_mag", mag_on, 1);
    check_eq("resume_no_load", n_loads, loads_snap);
    check_eq("resume_chain", chain, 16'h0005);
    pulse_stop();
    pulse_stop();
    check_eq("resume_idle", busy, 0);

    // Five digits shift the oldest out; 0xA is ignored.
    pulse_digit(4'd1); pulse_digit(4'd2); pulse_digit(4'd3);
    pulse_digit(4'd4); pulse_digit(4'd5); pulse_digit(4'hA);
    check_eq("shift_2345", cnt_data, 16'h2345);
    pulse_stop();
    check_eq("shift_stop", cnt_data, 0);
    check_eq("shift_idle", busy, 0);

    // Start ignored with zero entry or door open.
    pulse_digit(4'd0);
    pulse_start();
    step();
    check_eq("zero_start_busy", busy, 1);
    check_eq("zero_start_loadn", loadn, 1);
    pulse_digit(4'd7);
    door_closed = 1'b0;
    pulse_start();
    door_closed = 1'b1;
    step();
    check_eq("open_start_loadn", loadn, 1);
    check_eq("open_start_mag", mag_on, 0);
    check_eq("open_start_data", cnt_data, 16'h0007);
    pulse_stop();

    // Start from IDLE.
    loads_snap = n_loads;
`ifdef QUICK_START_EN
    exp_q.push_back(16'h0030);
    pulse_start();
    check_eq("qs_data", cnt_data, 16'h0030);
    check_eq("qs_loadn", loadn, 0);
    step();
    check_eq("qs_mag", mag_on, 1);
    pulse_stop();
    pulse_stop();
`else
    pulse_start();
    step();
    check_eq("idle_start_busy", busy, 0);
    check_eq("idle_start_loads", n_loads, loads_snap);
`endif

    // Asynchronous reset mid-cook.
    pulse_digit(4'd9);
    exp_q.push_back(16'h0009);
    pulse_start();
    step();
    check_eq("precl_mag", mag_on, 1);
    clrn = 1'b0;
    #1;
    check_eq("clr_mag", mag_on, 0);
    check_eq("clr_busy", busy, 0);
    check_eq("clr_data", cnt_data, 0);
    check_eq("clr_loadn", loadn, 1);
    step();
    clrn = 1'b1;
    step();

    check_eq("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
